// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, instruction
// fields, instruction classes and ALU operation codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_S  = 4'd4,
    S_CMP     = 4'd5,
    S_ALU_WB  = 4'd6,
    S_MEM_ADR = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WB  = 4'd9,
    S_MEM_WR  = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_SHIFT,
    CLS_CMP,
    CLS_LDR,
    CLS_STR,
    CLS_ILLEGAL
  } iclass_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;

  localparam logic [5:0] FN_ADD   = 6'b001000;
  localparam logic [5:0] FN_SUB   = 6'b000100;
  localparam logic [5:0] FN_AND   = 6'b000000;
  localparam logic [5:0] FN_ORR   = 6'b011000;
  localparam logic [5:0] FN_CMP   = 6'b010101;
  localparam logic [5:0] FN_SHIFT = 6'b011010;
  localparam logic [5:0] FN_STR   = 6'b011000;
  localparam logic [5:0] FN_LDR   = 6'b011001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_LSR = 3'b100;
  localparam logic [2:0] ALU_LSL = 3'b101;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: maps the IR to an instruction class,
// the ALU operation it needs and a legal flag.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic [2:0]  alu_ctrl,
  output logic        legal
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [1:0] sh;
  logic       unused_bits;

  assign op          = instr[27:26];
  assign funct       = instr[25:20];
  assign sh          = instr[6:5];
  assign unused_bits = ^{instr[31:28], instr[19:7], instr[4:0]};

  always_comb begin
    cls      = CLS_ILLEGAL;
    alu_ctrl = ALU_ADD;
    if (op == OP_DP) begin
      unique case (funct)
        FN_ADD: begin cls = CLS_ALU; alu_ctrl = ALU_ADD; end
        FN_SUB: begin cls = CLS_ALU; alu_ctrl = ALU_SUB; end
        FN_AND: begin cls = CLS_ALU; alu_ctrl = ALU_AND; end
        FN_ORR: begin cls = CLS_ALU; alu_ctrl = ALU_ORR; end
        FN_CMP: begin cls = CLS_CMP; alu_ctrl = ALU_SUB; end
        FN_SHIFT: begin
          // Only the two shift kinds the datapath implements are legal.
          if (sh == SH_LSL) begin
            cls      = CLS_SHIFT;
            alu_ctrl = ALU_LSL;
          end else if (sh == SH_LSR) begin
            cls      = CLS_SHIFT;
            alu_ctrl = ALU_LSR;
          end
        end
        default: ;
      endcase
    end else if (op == OP_MEM) begin
      if (funct == FN_STR)      cls = CLS_STR;
      else if (funct == FN_LDR) cls = CLS_LDR;
    end
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the ARM-subset datapath: FSM, memory-wait timeout
// counter and retired-instruction counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      Instruction,
  input  logic             mem_ready,
  output logic             PCwrite,
  output logic             AdrSrc,
  output logic             Instwen,
  output logic             Regwen,
  output logic             Regsel,
  output logic             Aluasel,
  output logic             Alubsel,
  output logic [2:0]       ALUcontrol,
  output logic             ImmSourceControl,
  output logic             Resultsel,
  output logic             MemoryWrite,
  output logic             Flagwrite,
  output logic             illegal_instr,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_next;
  logic [CNT_W-1:0] tcnt_q, tcnt_next, tcnt_inc;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  iclass_t          dec_cls;
  logic [2:0]       dec_alu;
  logic             dec_legal;

  instr_decoder u_dec (
    .instr    (Instruction),
    .cls      (dec_cls),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  assign tcnt_inc = tcnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_next;
      tcnt_q  <= tcnt_next;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_next       = state_q;
    tcnt_next        = '0;
    retire           = 1'b0;
    PCwrite          = 1'b0;
    AdrSrc           = 1'b0;
    Instwen          = 1'b0;
    Regwen           = 1'b0;
    Regsel           = 1'b0;
    Aluasel          = 1'b0;
    Alubsel          = 1'b0;
    ALUcontrol       = ALU_ADD;
    ImmSourceControl = 1'b0;
    Resultsel        = 1'b0;
    MemoryWrite      = 1'b0;
    Flagwrite        = 1'b0;
    illegal_instr    = 1'b0;
    halted           = 1'b0;

    unique case (state_q)
      S_IDLE: if (run) state_next = S_FETCH;

      S_FETCH: begin
        if (mem_ready) begin
          Instwen    = 1'b1;
          PCwrite    = 1'b1;
          state_next = S_DECODE;
        end else begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == TIMEOUT_LIM) state_next = S_HALT;
        end
      end

      S_DECODE: begin
        if (!dec_legal) begin
          illegal_instr = 1'b1;
          state_next    = S_FETCH;
        end else begin
          unique case (dec_cls)
            CLS_ALU:   state_next = S_EXEC_R;
            CLS_SHIFT: state_next = S_EXEC_S;
            CLS_CMP:   state_next = S_CMP;
            default:   state_next = S_MEM_ADR;
          endcase
        end
      end

      S_EXEC_R: begin
        ALUcontrol = dec_alu;
        state_next = S_ALU_WB;
      end

      S_EXEC_S: begin
        Aluasel    = 1'b1;
        Alubsel    = 1'b1;
        ALUcontrol = dec_alu;
        state_next = S_ALU_WB;
      end

      S_CMP: begin
        ALUcontrol = ALU_SUB;
        Flagwrite  = 1'b1;
        retire     = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end

      S_ALU_WB: begin
        // The IR is stable, so the execute-state selects are re-derived from it.
        Regwen     = 1'b1;
        Resultsel  = 1'b1;
        Aluasel    = (dec_cls == CLS_SHIFT);
        Alubsel    = (dec_cls == CLS_SHIFT);
        ALUcontrol = dec_alu;
        retire     = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end

      S_MEM_ADR: begin
        Regsel           = 1'b1;
        Alubsel          = 1'b1;
        ImmSourceControl = 1'b1;
        state_next       = (dec_cls == CLS_LDR) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        AdrSrc           = 1'b1;
        Regsel           = 1'b1;
        Alubsel          = 1'b1;
        ImmSourceControl = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == TIMEOUT_LIM) state_next = S_HALT;
        end
      end

      S_MEM_WB: begin
        Regwen     = 1'b1;
        Regsel     = 1'b1;
        retire     = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end

      S_MEM_WR: begin
        AdrSrc      = 1'b1;
        MemoryWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = run ? S_FETCH : S_IDLE;
        end else begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == TIMEOUT_LIM) state_next = S_HALT;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_IDLE;
    endcase
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// are queued as each cycle is driven and checked at the following falling edge.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] Instruction;
  logic        mem_ready;
  logic        PCwrite, AdrSrc, Instwen, Regwen, Regsel, Aluasel, Alubsel;
  logic [2:0]  ALUcontrol;
  logic        ImmSourceControl, Resultsel, MemoryWrite, Flagwrite;
  logic        illegal_instr, halted;
  logic [7:0]  retired;
  logic [3:0]  state;

  int tests = 0;
  int fails = 0;
  logic [19:0] sb_q[$];

  localparam logic [31:0] I_ADD = 32'h0080_0000;
  localparam logic [31:0] I_SUB = 32'h0040_0000;
  localparam logic [31:0] I_LSR = 32'h01A0_0020;
  localparam logic [31:0] I_CMP = 32'h0150_0000;
  localparam logic [31:0] I_ILL = 32'h0C00_0000;
  localparam logic [31:0] I_STR = 32'h0580_0000;
  localparam logic [31:0] I_LDR = 32'h0590_0000;

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .Instruction      (Instruction),
    .mem_ready        (mem_ready),
    .PCwrite          (PCwrite),
    .AdrSrc           (AdrSrc),
    .Instwen          (Instwen),
    .Regwen           (Regwen),
    .Regsel           (Regsel),
    .Aluasel          (Aluasel),
    .Alubsel          (Alubsel),
    .ALUcontrol       (ALUcontrol),
    .ImmSourceControl (ImmSourceControl),
    .Resultsel        (Resultsel),
    .MemoryWrite      (MemoryWrite),
    .Flagwrite        (Flagwrite),
    .illegal_instr    (illegal_instr),
    .halted           (halted),
    .retired          (retired),
    .state            (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] v(input logic [3:0] st,
                                    input logic pcw, adr, iw, rw, rs, as_, bs,
                                    input logic [2:0] alu,
                                    input logic imm, res, mw, fw, ill, hlt);
    return {st, pcw, adr, iw, rw, rs, as_, bs, alu, imm, res, mw, fw, ill, hlt};
  endfunction

  function automatic logic [19:0] observed();
    return {state, PCwrite, AdrSrc, Instwen, Regwen, Regsel, Aluasel, Alubsel,
            ALUcontrol, ImmSourceControl, Resultsel, MemoryWrite, Flagwrite,
            illegal_instr, halted};
  endfunction

  // Drive one cycle, queue its expected outputs, check at the falling edge.
  task automatic cyc(input logic mr, input logic [19:0] e, input string tag);
    logic [19:0] got, want;
    mem_ready = mr;
    sb_q.push_back(e);
    @(negedge clk);
    got  = observed();
    want = sb_q.pop_front();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  logic [19:0] V_IDLE, V_FETCH, V_FWAIT, V_DEC, V_DEC_ILL, V_CMP;
  logic [19:0] V_MADR, V_MRD, V_MWB, V_MWR, V_HALT;

  initial begin
    V_IDLE    = v(4'd0,  0,0,0,0,0,0,0, 3'b000, 0,0,0,0,0,0);
    V_FETCH   = v(4'd1,  1,0,1,0,0,0,0, 3'b000, 0,0,0,0,0,0);
    V_FWAIT   = v(4'd1,  0,0,0,0,0,0,0, 3'b000, 0,0,0,0,0,0);
    V_DEC     = v(4'd2,  0,0,0,0,0,0,0, 3'b000, 0,0,0,0,0,0);
    V_DEC_ILL = v(4'd2,  0,0,0,0,0,0,0, 3'b000, 0,0,0,0,1,0);
    V_CMP     = v(4'd5,  0,0,0,0,0,0,0, 3'b001, 0,0,0,1,0,0);
    V_MADR    = v(4'd7,  0,0,0,0,1,0,1, 3'b000, 1,0,0,0,0,0);
    V_MRD     = v(4'd8,  0,1,0,0,1,0,1, 3'b000, 1,0,0,0,0,0);
    V_MWB     = v(4'd9,  0,0,0,1,1,0,0, 3'b000, 0,0,0,0,0,0);
    V_MWR     = v(4'd10, 0,1,0,0,0,0,0, 3'b000, 0,0,1,0,0,0);
    V_HALT    = v(4'd11, 0,0,0,0,0,0,0, 3'b000, 0,0,0,0,0,1);

    rst = 1'b0; run = 1'b0; mem_ready = 1'b1; Instruction = I_ADD;
    #12;
    chk("reset_outputs", {12'd0, observed()}, {12'd0, V_IDLE});
    chk("reset_retired", {24'd0, retired}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    cyc(1, V_IDLE, "idle_run0");
    run = 1'b1;
    cyc(1, V_IDLE, "idle_run1");

    // ADD: 1,2,3,6 then back to FETCH
    cyc(1, V_FETCH, "add_fetch");
    cyc(1, V_DEC, "add_decode");
    cyc(1, v(4'd3, 0,0,0,0,0,0,0, 3'b000, 0,0,0,0,0,0), "add_exec");
    cyc(1, v(4'd6, 0,0,0,1,0,0,0, 3'b000, 0,1,0,0,0,0), "add_wb");
    chk("add_retired", {24'd0, retired}, 32'd1);

    Instruction = I_SUB;
    cyc(1, V_FETCH, "sub_fetch");
    cyc(1, V_DEC, "sub_decode");
    cyc(1, v(4'd3, 0,0,0,0,0,0,0, 3'b001, 0,0,0,0,0,0), "sub_exec");
    cyc(1, v(4'd6, 0,0,0,1,0,0,0, 3'b001, 0,1,0,0,0,0), "sub_wb");

    Instruction = I_LSR;
    cyc(1, V_FETCH, "lsr_fetch");
    cyc(1, V_DEC, "lsr_decode");
    cyc(1, v(4'd4, 0,0,0,0,0,1,1, 3'b100, 0,0,0,0,0,0), "lsr_exec");
    cyc(1, v(4'd6, 0,0,0,1,0,1,1, 3'b100, 0,1,0,0,0,0), "lsr_wb");
    chk("lsr_retired", {24'd0, retired}, 32'd3);

    Instruction = I_CMP;
    cyc(1, V_FETCH, "cmp_fetch");
    cyc(1, V_DEC, "cmp_decode");
    cyc(1, V_CMP, "cmp_exec");
    chk("cmp_retired", {24'd0, retired}, 32'd4);

    Instruction = I_ILL;
    cyc(1, V_FETCH, "ill_fetch");
    cyc(1, V_DEC_ILL, "ill_decode");
    chk("ill_next_state", {28'd0, state}, 32'd1);
    chk("ill_retired", {24'd0, retired}, 32'd4);

    // LDR with three wait cycles in MEM_RD
    Instruction = I_LDR;
    cyc(1, V_FETCH, "ldr_fetch");
    cyc(1, V_DEC, "ldr_decode");
    cyc(1, V_MADR, "ldr_adr");
    for (int i = 0; i < 3; i++) cyc(0, V_MRD, "ldr_rd_wait");
    cyc(1, V_MRD, "ldr_rd_done");
    cyc(1, V_MWB, "ldr_wb");
    chk("ldr_retired", {24'd0, retired}, 32'd5);

    // STR after a fetch wait; run drops mid-instruction
    Instruction = I_STR;
    cyc(0, V_FWAIT, "str_fetch_wait");
    cyc(0, V_FWAIT, "str_fetch_wait");
    cyc(1, V_FETCH, "str_fetch");
    cyc(1, V_DEC, "str_decode");
    run = 1'b0;
    cyc(1, V_MADR, "str_adr");
    cyc(1, V_MWR, "str_write");
    cyc(1, V_IDLE, "str_then_idle");
    chk("str_retired", {24'd0, retired}, 32'd6);
    run = 1'b1;
    cyc(1, V_IDLE, "idle_restart");

    // LDR: 14 waits then ready on the 15th cycle must still complete
    Instruction = I_LDR;
    cyc(1, V_FETCH, "ldr14_fetch");
    cyc(1, V_DEC, "ldr14_decode");
    cyc(1, V_MADR, "ldr14_adr");
    for (int i = 0; i < 14; i++) cyc(0, V_MRD, "ldr14_wait");
    cyc(1, V_MRD, "ldr14_ready");
    cyc(1, V_MWB, "ldr14_wb");
    chk("ldr14_retired", {24'd0, retired}, 32'd7);

    // STR timeout: 15 wait cycles then HALT, sticky
    Instruction = I_STR;
    cyc(1, V_FETCH, "sto_fetch");
    cyc(1, V_DEC, "sto_decode");
    cyc(1, V_MADR, "sto_adr");
    for (int i = 0; i < 15; i++) cyc(0, V_MWR, "sto_wait");
    cyc(1, V_HALT, "halt");
    cyc(1, V_HALT, "halt_sticky");
    chk("halt_retired", {24'd0, retired}, 32'd7);

    rst = 1'b0;
    #1;
    chk("rst_from_halt_state", {28'd0, state}, 32'd0);
    chk("rst_from_halt_halted", {31'd0, halted}, 32'd0);
    chk("rst_from_halt_retired", {24'd0, retired}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Async reset inside MEM_WR drops MemoryWrite before the next edge
    cyc(1, V_FETCH, "ar_fetch");
    cyc(1, V_DEC, "ar_decode");
    cyc(1, V_MADR, "ar_adr");
    mem_ready = 1'b0;
    #3;
    chk("ar_memwrite_before", {31'd0, MemoryWrite}, 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_memwrite_after", {31'd0, MemoryWrite}, 32'd0);
    chk("ar_state_after", {28'd0, state}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
